// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the memory stage: funct3 access codes, LSU FSM
// state encodings and the alignment rule used by the optional misalign check.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_RESP = 2'd2;

  // Loads and stores share the size encoding, so one rule covers both.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3 == F3_LH || f3 == F3_LHU) && a[0]) || (f3 == F3_LW && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/gnt/rvalid port; master = memory stage, slave = memory.
interface mem_wb_stage_if #(parameter int XLEN = 32);
  logic                dmem_req_o;
  logic                dmem_we_o;
  logic [XLEN-1:0]     dmem_addr_o;
  logic [XLEN/8-1:0]   dmem_be_o;
  logic [XLEN-1:0]     dmem_wdata_o;
  logic                dmem_gnt_i;
  logic                dmem_rvalid_i;
  logic [XLEN-1:0]     dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_wb_stage_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data and load
// byte/half selection with sign or zero extension. Purely combinational.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NUM_LANES = XLEN / 8
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [XLEN-1:0]      store_data,
  input  logic [XLEN-1:0]      rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      load_ext
);

  logic [NUM_LANES-1:0][7:0] sd_lanes, rd_lanes, wd_lanes;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;

  assign sd_lanes = store_data;
  assign rd_lanes = rdata;
  assign wdata    = wd_lanes;

  // Byte stores replicate lane 0 everywhere, half stores replicate the low half.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_comb begin
      case (funct3[1:0])
        F3_SB[1:0]: wd_lanes[g] = sd_lanes[0];
        F3_SH[1:0]: wd_lanes[g] = sd_lanes[g % 2];
        default:    wd_lanes[g] = sd_lanes[g];
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      F3_SB[1:0]: be = {{(NUM_LANES-1){1'b0}}, 1'b1} << addr_lo;
      F3_SH[1:0]: be = {{(NUM_LANES-2){1'b0}}, 2'b11} << {addr_lo[1], 1'b0};
      default:    be = '1;
    endcase
  end

  assign ld_byte = rd_lanes[addr_lo];
  assign ld_half = {rd_lanes[{addr_lo[1], 1'b1}], rd_lanes[{addr_lo[1], 1'b0}]};

  always_comb begin
    case (funct3)
      F3_LB:   load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   load_ext = rdata;
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: drives the data-memory port through an IDLE/REQ/RESP FSM, stalls
// until the access completes, resolves pc_src and registers MEM/WB.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses are dropped and flagged.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic              jal_i,
  input  logic              jalr_i,
  input  logic              zero_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [2:0]        funct3_i,
  input  logic [REG_AW-1:0] rd_i,
  mem_wb_stage_if.master    dmem,
  output logic              stall_o,
  output logic              pc_src_o,
  output logic              wb_reg_write_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  logic [1:0]        state_q, state_d;
  logic              mem_op, mem_op_eff, is_store, mis, req, done;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata, load_ext;

  assign mem_op   = mem_read_i | mem_write_i;
  assign is_store = mem_write_i;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = mem_op & misaligned(funct3_i, alu_result_i[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign mem_op_eff = mem_op & ~mis;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_i),
    .addr_lo    (alu_result_i[1:0]),
    .store_data (rs2_data_i),
    .rdata      (dmem.dmem_rdata_i),
    .be         (be),
    .wdata      (wdata),
    .load_ext   (load_ext)
  );

  // IDLE issues combinationally so a zero-wait grant completes in the same cycle.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    case (state_q)
      MEM_IDLE, MEM_REQ: begin
        if (state_q == MEM_REQ || mem_op_eff) begin
          req = 1'b1;
          if (dmem.dmem_gnt_i) begin
            done    = is_store;
            state_d = is_store ? MEM_IDLE : MEM_RESP;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_RESP: begin
        if (dmem.dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign dmem.dmem_req_o   = req & ~reset;
  assign dmem.dmem_we_o    = dmem.dmem_req_o & is_store;
  assign dmem.dmem_be_o    = dmem.dmem_req_o ? be : '0;
  assign dmem.dmem_addr_o  = {alu_result_i[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata_o = wdata;

  assign stall_o  = mem_op_eff & ~done;
  assign pc_src_o = (branch_i & zero_i) | jal_i | jalr_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= MEM_IDLE;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      misalign_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stall_o) begin
        wb_reg_write_o <= 1'b0;
        misalign_o     <= 1'b0;
      end else begin
        wb_reg_write_o <= reg_write_i & ~mis;
        wb_rd_o        <= rd_i;
        wb_data_o      <= mem_to_reg_i        ? load_ext   :
                          (jal_i | jalr_i)    ? pc_plus4_i : alu_result_i;
        misalign_o     <= mis;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-instruction vectors against
// a zero-wait memory, plus hand sequences for wait states, reset and misalign.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, jal_i, jalr_i, zero_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_plus4_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        stall_o, pc_src_o, wb_reg_write_o, misalign_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32)) dmem();

  mem_wb_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .branch_i       (branch_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .mem_to_reg_i   (mem_to_reg_i),
    .reg_write_i    (reg_write_i),
    .jal_i          (jal_i),
    .jalr_i         (jalr_i),
    .zero_i         (zero_i),
    .alu_result_i   (alu_result_i),
    .rs2_data_i     (rs2_data_i),
    .pc_plus4_i     (pc_plus4_i),
    .funct3_i       (funct3_i),
    .rd_i           (rd_i),
    .dmem           (dmem),
    .stall_o        (stall_o),
    .pc_src_o       (pc_src_o),
    .wb_reg_write_o (wb_reg_write_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .misalign_o     (misalign_o)
  );

  typedef struct {
    string       name;
    logic        br, zero, mr, mw, m2r, rw, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, pc4, rdata;
    logic [4:0]  rd;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_addr;
    logic        e_stall, e_pcsrc, e_wbwe;
    logic [31:0] e_wbdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nop();
    {branch_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, jal_i, jalr_i, zero_i} = '0;
    alu_result_i = '0; rs2_data_i = '0; pc_plus4_i = '0; funct3_i = '0; rd_i = '0;
  endtask

  task automatic set_ctl(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [4:0] rd);
    nop();
    mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r; reg_write_i = rw;
    funct3_i = f3; alu_result_i = alu; rd_i = rd;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    branch_i = v.br; zero_i = v.zero; mem_read_i = v.mr; mem_write_i = v.mw;
    mem_to_reg_i = v.m2r; reg_write_i = v.rw; jal_i = v.jal; jalr_i = v.jalr;
    funct3_i = v.f3; alu_result_i = v.alu; rs2_data_i = v.rs2; pc_plus4_i = v.pc4; rd_i = v.rd;
    dmem.dmem_gnt_i = v.mr | v.mw; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = v.rdata;
    @(negedge clk);
    chk({v.name, ".req"},    32'(dmem.dmem_req_o), 32'(v.e_req));
    chk({v.name, ".we"},     32'(dmem.dmem_we_o),  32'(v.e_we));
    chk({v.name, ".be"},     32'(dmem.dmem_be_o),  32'(v.e_be));
    if (v.e_req) chk({v.name, ".addr"},  dmem.dmem_addr_o,  v.e_addr);
    if (v.e_we)  chk({v.name, ".wdata"}, dmem.dmem_wdata_o, v.e_wdata);
    chk({v.name, ".stall"},  32'(stall_o),  32'(v.e_stall));
    chk({v.name, ".pc_src"}, 32'(pc_src_o), 32'(v.e_pcsrc));
    if (v.mr & ~v.mw) begin
      @(posedge clk); #1;
      dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b1;
      @(negedge clk);
      chk({v.name, ".stall_resp"}, 32'(stall_o), 32'd0);
    end
    @(posedge clk); #1;
    nop(); dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk({v.name, ".wb_we"},   32'(wb_reg_write_o), 32'(v.e_wbwe));
    chk({v.name, ".wb_rd"},   32'(wb_rd_o),        32'(v.rd));
    chk({v.name, ".wb_data"}, wb_data_o,           v.e_wbdata);
    chk({v.name, ".misal"},   32'(misalign_o),     32'd0);
  endtask

  initial begin
    int stall_cnt, wr_cnt;
    logic stable_ok;

    //            name       br zr mr mw m2r rw jal jalr f3      alu           rs2           pc4          rdata         rd    req we be     wdata         addr          stl pcs wbwe wbdata
    vecs[0]  = '{"lw",      0, 0, 1, 0, 1,  1, 0,  0,   3'b010, 32'h100,      32'h0,        32'h4,       32'hDEADBEEF, 5'd5, 1, 0, 4'hF, 32'h0,        32'h100,      1,  0,  1,   32'hDEADBEEF};
    vecs[1]  = '{"sb",      0, 0, 0, 1, 0,  0, 0,  0,   3'b000, 32'h103,      32'h000000AB, 32'h0,       32'h0,        5'd0, 1, 1, 4'h8, 32'hABABABAB, 32'h100,      0,  0,  0,   32'h103};
    vecs[2]  = '{"lb",      0, 0, 1, 0, 1,  1, 0,  0,   3'b000, 32'h102,      32'h0,        32'h0,       32'h00800000, 5'd6, 1, 0, 4'h4, 32'h0,        32'h100,      1,  0,  1,   32'hFFFFFF80};
    vecs[3]  = '{"lbu",     0, 0, 1, 0, 1,  1, 0,  0,   3'b100, 32'h102,      32'h0,        32'h0,       32'h00800000, 5'd6, 1, 0, 4'h4, 32'h0,        32'h100,      1,  0,  1,   32'h00000080};
    vecs[4]  = '{"lh",      0, 0, 1, 0, 1,  1, 0,  0,   3'b001, 32'h102,      32'h0,        32'h0,       32'h80010000, 5'd7, 1, 0, 4'hC, 32'h0,        32'h100,      1,  0,  1,   32'hFFFF8001};
    vecs[5]  = '{"lhu",     0, 0, 1, 0, 1,  1, 0,  0,   3'b101, 32'h100,      32'h0,        32'h0,       32'h1234F00F, 5'd8, 1, 0, 4'h3, 32'h0,        32'h100,      1,  0,  1,   32'h0000F00F};
    vecs[6]  = '{"sh",      0, 0, 0, 1, 0,  0, 0,  0,   3'b001, 32'h102,      32'h1234BEEF, 32'h0,       32'h0,        5'd0, 1, 1, 4'hC, 32'hBEEFBEEF, 32'h100,      0,  0,  0,   32'h102};
    vecs[7]  = '{"sw",      0, 0, 0, 1, 0,  0, 0,  0,   3'b010, 32'h104,      32'hCAFEF00D, 32'h0,       32'h0,        5'd0, 1, 1, 4'hF, 32'hCAFEF00D, 32'h104,      0,  0,  0,   32'h104};
    vecs[8]  = '{"jal",     0, 0, 0, 0, 0,  1, 1,  0,   3'b000, 32'h999,      32'h0,        32'h44,      32'h0,        5'd1, 0, 0, 4'h0, 32'h0,        32'h0,        0,  1,  1,   32'h44};
    vecs[9]  = '{"alu",     0, 0, 0, 0, 0,  1, 0,  0,   3'b000, 32'h12345678, 32'h0,        32'h0,       32'h0,        5'd9, 0, 0, 4'h0, 32'h0,        32'h0,        0,  0,  1,   32'h12345678};
    vecs[10] = '{"beq_t",   1, 1, 0, 0, 0,  0, 0,  0,   3'b000, 32'h0,        32'h0,        32'h0,       32'h0,        5'd0, 0, 0, 4'h0, 32'h0,        32'h0,        0,  1,  0,   32'h0};
    vecs[11] = '{"beq_nt",  1, 0, 0, 0, 0,  0, 0,  0,   3'b000, 32'h5,        32'h0,        32'h0,       32'h0,        5'd0, 0, 0, 4'h0, 32'h0,        32'h0,        0,  0,  0,   32'h5};
    vecs[12] = '{"jalr",    0, 0, 0, 0, 0,  1, 0,  1,   3'b000, 32'h2000,     32'h0,        32'h1000,    32'h0,        5'd1, 0, 0, 4'h0, 32'h0,        32'h0,        0,  1,  1,   32'h1000};
    vecs[13] = '{"rd_wr",   0, 0, 1, 1, 0,  0, 0,  0,   3'b010, 32'h108,      32'h11223344, 32'h0,       32'h0,        5'd0, 1, 1, 4'hF, 32'h11223344, 32'h108,      0,  0,  0,   32'h108};

    reset = 1'b1;
    nop();
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req",   32'(dmem.dmem_req_o), 32'd0);
    chk("rst.be",    32'(dmem.dmem_be_o),  32'd0);
    chk("rst.wb_we", 32'(wb_reg_write_o),  32'd0);
    chk("rst.wb_rd", 32'(wb_rd_o),         32'd0);
    chk("rst.wb_d",  wb_data_o,            32'd0);
    chk("rst.misal", 32'(misalign_o),      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Grant arrives in cycle 3, rvalid in cycle 5: five stall cycles, one write.
    @(posedge clk); #1;
    set_ctl(1, 0, 1, 1, 3'b010, 32'h200, 5'd10);
    dmem.dmem_rdata_i = 32'h0BADF00D;
    stall_cnt = 0; wr_cnt = 0; stable_ok = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      dmem.dmem_gnt_i    = (cyc == 3);
      dmem.dmem_rvalid_i = (cyc == 5);
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (wb_reg_write_o) wr_cnt++;
      if (cyc <= 3 && (dmem.dmem_req_o !== 1'b1 || dmem.dmem_addr_o !== 32'h200)) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    nop(); dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    if (wb_reg_write_o) wr_cnt++;
    chk("wait.wb_data", wb_data_o, 32'h0BADF00D);
    chk("wait.wb_rd",   32'(wb_rd_o), 32'd10);
    @(posedge clk);
    @(negedge clk);
    if (wb_reg_write_o) wr_cnt++;
    chk("wait.stall_cnt", 32'(stall_cnt), 32'd5);
    chk("wait.wr_cnt",    32'(wr_cnt),    32'd1);
    chk("wait.req_hold",  32'(stable_ok), 32'd1);

    // Reset while waiting for rvalid; stray rvalids afterwards must be ignored.
    @(posedge clk); #1;
    set_ctl(1, 0, 1, 1, 3'b010, 32'h300, 5'd11);
    dmem.dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rstresp.stall0", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; dmem.dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rstresp.req1", 32'(dmem.dmem_req_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; nop();
    dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h77;
    @(negedge clk);
    chk("rstresp.req2",   32'(dmem.dmem_req_o), 32'd0);
    chk("rstresp.wb_we2", 32'(wb_reg_write_o),  32'd0);
    chk("rstresp.stall2", 32'(stall_o),         32'd0);
    @(posedge clk); #1;
    set_ctl(1, 0, 1, 1, 3'b010, 32'h304, 5'd12);
    dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h99;
    @(negedge clk);
    chk("rstresp.req3",   32'(dmem.dmem_req_o), 32'd1);
    chk("rstresp.stall3", 32'(stall_o),         32'd1);
    chk("rstresp.wb_we3", 32'(wb_reg_write_o),  32'd0);
    @(posedge clk); #1;
    dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rstresp.wb_we4", 32'(wb_reg_write_o), 32'd0);
    @(posedge clk); #1;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    chk("rstresp.stall5", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    nop(); dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rstresp.wb_we", 32'(wb_reg_write_o), 32'd1);
    chk("rstresp.wb_d",  wb_data_o,           32'h55AA55AA);
    chk("rstresp.wb_rd", 32'(wb_rd_o),        32'd12);

`ifdef MEM_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    set_ctl(1, 0, 1, 1, 3'b010, 32'h102, 5'd3);
    @(negedge clk);
    chk("mis.lw.req",   32'(dmem.dmem_req_o), 32'd0);
    chk("mis.lw.stall", 32'(stall_o),         32'd0);
    @(posedge clk); #1;
    set_ctl(0, 1, 0, 0, 3'b001, 32'h101, 5'd0);
    @(negedge clk);
    chk("mis.lw.pulse", 32'(misalign_o),      32'd1);
    chk("mis.lw.wb_we", 32'(wb_reg_write_o),  32'd0);
    chk("mis.sh.req",   32'(dmem.dmem_req_o), 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    chk("mis.sh.pulse", 32'(misalign_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mis.clear", 32'(misalign_o), 32'd0);
`else
    @(posedge clk); #1;
    set_ctl(1, 0, 1, 1, 3'b010, 32'h102, 5'd3);
    dmem.dmem_gnt_i = 1'b1; dmem.dmem_rdata_i = 32'hA5A50001;
    @(negedge clk);
    chk("mis.lw.req",  32'(dmem.dmem_req_o), 32'd1);
    chk("mis.lw.addr", dmem.dmem_addr_o,     32'h100);
    chk("mis.lw.be",   32'(dmem.dmem_be_o),  32'hF);
    @(posedge clk); #1;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b1;
    @(posedge clk); #1;
    nop(); dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("mis.lw.wb_d",  wb_data_o,           32'hA5A50001);
    chk("mis.lw.wb_we", 32'(wb_reg_write_o), 32'd1);
    chk("mis.lw.pulse", 32'(misalign_o),     32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
